// File: rtl/l2_req_arbiter.sv
// ---------------------------------------------------------------------------
// l2_req_arbiter
// Shares the single L2 cache port between the L1 I-cache (refill reads) and
// the L1 D-cache (refill reads and dirty-line write-backs). A winner is
// picked in IDLE, and its op, line-aligned address and write data are latched.
// The grant is held until L2 acknowledges. The ack and read data are then
// routed back to the winner only.
//
// Parameters
//   ARB_MODE  0 = round-robin between I and D, 1 = fixed priority (D wins)
//   LINE_OFS  number of low address bits cleared on the L2 address
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   I_cache_req/_req_addr       I-cache line read request (level) and address
//   I_cache_ack/_rd_data        completion pulse and refill line to I-cache
//   D_cache_req/_req_op/_addr   D-cache request (level), op (1=write), address
//   D_cache_wr_data             D-cache write-back line
//   L2_cache_ack_D_cache        completion pulse to D-cache
//   D_cache_rd_data             refill line to D-cache
//   L2_req/_op/_addr/_wr_data   request towards L2, driven from latched regs
//   L2_ack/L2_rd_data           L2 completion pulse and read line
//   owner                       debug: 00 idle, 01 I granted, 10 D granted
// ---------------------------------------------------------------------------
module l2_req_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int LINE_OFS = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         I_cache_req,
    input  logic [31:0]  I_cache_req_addr,
    output logic         I_cache_ack,
    output logic [511:0] I_cache_rd_data,
    input  logic         D_cache_req,
    input  logic         D_cache_req_op,
    input  logic [31:0]  D_cache_req_addr,
    input  logic [511:0] D_cache_wr_data,
    output logic         L2_cache_ack_D_cache,
    output logic [511:0] D_cache_rd_data,
    output logic         L2_req,
    output logic         L2_req_op,
    output logic [31:0]  L2_req_addr,
    output logic [511:0] L2_wr_data,
    input  logic         L2_ack,
    input  logic [511:0] L2_rd_data,
    output logic [1:0]   owner
);

    localparam logic [1:0]  ST_IDLE    = 2'b00;
    localparam logic [1:0]  ST_GNT_I   = 2'b01;
    localparam logic [1:0]  ST_GNT_D   = 2'b10;
    localparam logic        FIXED_PRIO = (ARB_MODE == 1) ? 1'b1 : 1'b0;
    localparam logic [31:0] LINE_MASK  = ~((32'd1 << LINE_OFS) - 32'd1);

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic         r_last_gnt_d;   // 0: I was granted last, 1: D was granted last
    logic         r_op;
    logic [31:0]  r_addr;
    logic [511:0] r_wr_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: arbitration in IDLE, wait for L2_ack in a grant state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (I_cache_req && D_cache_req) begin
                    // Round-robin favours whoever was not served last
                    if (FIXED_PRIO || !r_last_gnt_d) begin
                        w_next_state = ST_GNT_D;
                    end else begin
                        w_next_state = ST_GNT_I;
                    end
                end else if (D_cache_req) begin
                    w_next_state = ST_GNT_D;
                end else if (I_cache_req) begin
                    w_next_state = ST_GNT_I;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (L2_ack) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request latch: capture the winner's op/address/data when leaving IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt_d <= 1'b0;
            r_op         <= 1'b0;
            r_addr       <= 32'd0;
            r_wr_data    <= 512'd0;
        end else if ((r_state == ST_IDLE) && (w_next_state == ST_GNT_D)) begin
            r_last_gnt_d <= 1'b1;
            r_op         <= D_cache_req_op;
            r_addr       <= D_cache_req_addr & LINE_MASK;
            // Refills leave the previous write line in place
            if (D_cache_req_op) begin
                r_wr_data <= D_cache_wr_data;
            end else begin
                r_wr_data <= r_wr_data;
            end
        end else if ((r_state == ST_IDLE) && (w_next_state == ST_GNT_I)) begin
            r_last_gnt_d <= 1'b0;
            r_op         <= 1'b0;
            r_addr       <= I_cache_req_addr & LINE_MASK;
            r_wr_data    <= r_wr_data;
        end else begin
            r_last_gnt_d <= r_last_gnt_d;
            r_op         <= r_op;
            r_addr       <= r_addr;
            r_wr_data    <= r_wr_data;
        end
    end

    // Output logic: ack and read data go back to the winner only, in the ack cycle
    always_comb begin
        I_cache_ack          = 1'b0;
        I_cache_rd_data      = 512'd0;
        L2_cache_ack_D_cache = 1'b0;
        D_cache_rd_data      = 512'd0;
        case (r_state)
            ST_GNT_I: begin
                if (L2_ack) begin
                    I_cache_ack     = 1'b1;
                    I_cache_rd_data = L2_rd_data;
                end else begin
                    I_cache_ack     = 1'b0;
                    I_cache_rd_data = 512'd0;
                end
            end
            ST_GNT_D: begin
                if (L2_ack) begin
                    L2_cache_ack_D_cache = 1'b1;
                    D_cache_rd_data      = L2_rd_data;
                end else begin
                    L2_cache_ack_D_cache = 1'b0;
                    D_cache_rd_data      = 512'd0;
                end
            end
            default: begin
                I_cache_ack          = 1'b0;
                L2_cache_ack_D_cache = 1'b0;
            end
        endcase
    end

    assign L2_req      = (r_state != ST_IDLE);
    assign L2_req_op   = r_op;
    assign L2_req_addr = r_addr;
    assign L2_wr_data  = r_wr_data;
    assign owner       = r_state;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for l2_req_arbiter. Two instances share all
// inputs: u0 in round-robin mode, u1 in fixed-priority mode. Inputs change
// 2 time units after the rising edge; outputs are sampled before the next edge.
// ---------------------------------------------------------------------------
module tb_l2_req_arbiter;

    logic         clk;
    logic         rst_n;
    logic         I_cache_req;
    logic [31:0]  I_cache_req_addr;
    logic         D_cache_req;
    logic         D_cache_req_op;
    logic [31:0]  D_cache_req_addr;
    logic [511:0] D_cache_wr_data;
    logic         L2_ack;
    logic [511:0] L2_rd_data;

    logic         i_ack0, d_ack0, req0, op0;
    logic [511:0] i_rd0, d_rd0, wr0;
    logic [31:0]  addr0;
    logic [1:0]   own0;
    logic         i_ack1, d_ack1, req1, op1;
    logic [511:0] i_rd1, d_rd1, wr1;
    logic [31:0]  addr1;
    logic [1:0]   own1;

    int checks   = 0;
    int failures = 0;

    l2_req_arbiter #(.ARB_MODE(0), .LINE_OFS(6)) u0 (
        .clk(clk), .rst_n(rst_n),
        .I_cache_req(I_cache_req), .I_cache_req_addr(I_cache_req_addr),
        .I_cache_ack(i_ack0), .I_cache_rd_data(i_rd0),
        .D_cache_req(D_cache_req), .D_cache_req_op(D_cache_req_op),
        .D_cache_req_addr(D_cache_req_addr), .D_cache_wr_data(D_cache_wr_data),
        .L2_cache_ack_D_cache(d_ack0), .D_cache_rd_data(d_rd0),
        .L2_req(req0), .L2_req_op(op0), .L2_req_addr(addr0), .L2_wr_data(wr0),
        .L2_ack(L2_ack), .L2_rd_data(L2_rd_data), .owner(own0)
    );

    l2_req_arbiter #(.ARB_MODE(1), .LINE_OFS(6)) u1 (
        .clk(clk), .rst_n(rst_n),
        .I_cache_req(I_cache_req), .I_cache_req_addr(I_cache_req_addr),
        .I_cache_ack(i_ack1), .I_cache_rd_data(i_rd1),
        .D_cache_req(D_cache_req), .D_cache_req_op(D_cache_req_op),
        .D_cache_req_addr(D_cache_req_addr), .D_cache_wr_data(D_cache_wr_data),
        .L2_cache_ack_D_cache(d_ack1), .D_cache_rd_data(d_rd1),
        .L2_req(req1), .L2_req_op(op1), .L2_req_addr(addr1), .L2_wr_data(wr1),
        .L2_ack(L2_ack), .L2_rd_data(L2_rd_data), .owner(own1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [511:0] pat_a5;
    logic [511:0] pat_rd;
    logic [511:0] pat_wr;
    logic [1:0]   exp_own0 [4];
    logic [31:0]  exp_addr0 [4];
    logic         exp_op0 [4];

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_rd = {16{32'hDEADBEEF}};
        pat_wr = {16{32'h3C3C_0F0F}};
        exp_own0  = '{2'b10, 2'b01, 2'b10, 2'b01};
        exp_addr0 = '{32'h4000_0100, 32'h8000_0040, 32'h4000_0100, 32'h8000_0040};
        exp_op0   = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; I_cache_req = 1'b0; I_cache_req_addr = 32'd0;
        D_cache_req = 1'b0; D_cache_req_op = 1'b0; D_cache_req_addr = 32'd0;
        D_cache_wr_data = 512'd0; L2_ack = 1'b0; L2_rd_data = 512'd0;

        // Reset state
        tick(); tick();
        chk("rst_owner", own0, 2'b00);
        chk("rst_req", req0, 1'b0);
        chk("rst_addr", addr0, 32'd0);
        chk("rst_wr", wr0, 512'd0);
        chk("rst_acks", {i_ack0, d_ack0, i_ack1, d_ack1}, 4'b0000);
        rst_n = 1'b1;
        tick();

        // Single D read, L2_ack three cycles after L2_req
        D_cache_req = 1'b1; D_cache_req_op = 1'b0; D_cache_req_addr = 32'h1234_5678;
        #1 chk("drd_no_req_yet", req0, 1'b0);
        tick();
        chk("drd_req", req0, 1'b1);
        chk("drd_owner", own0, 2'b10);
        chk("drd_addr", addr0, 32'h1234_5640);
        chk("drd_op", op0, 1'b0);
        tick(); tick();
        chk("drd_no_ack", {i_ack0, d_ack0}, 2'b00);
        chk("drd_rd_zero", d_rd0, 512'd0);
        L2_ack = 1'b1; L2_rd_data = pat_rd; D_cache_req = 1'b0;
        #1 chk("drd_ack", d_ack0, 1'b1);
        chk("drd_rd", d_rd0, pat_rd);
        chk("drd_i_ack", i_ack0, 1'b0);
        chk("drd_i_rd", i_rd0, 512'd0);
        tick(); L2_ack = 1'b0;
        #1 chk("drd_idle", {own0, req0}, 3'b000);
        chk("drd_ack_gone", d_rd0, 512'd0);

        // D write-back: data must stay latched even if the inputs move
        D_cache_req = 1'b1; D_cache_req_op = 1'b1; D_cache_req_addr = 32'h0000_1FFF;
        D_cache_wr_data = pat_a5;
        tick();
        chk("dwr_op", op0, 1'b1);
        chk("dwr_addr", addr0, 32'h0000_1FC0);
        chk("dwr_data", wr0, pat_a5);
        D_cache_wr_data = 512'd0; D_cache_req_addr = 32'h0BAD_0000; D_cache_req_op = 1'b0;
        tick();
        chk("dwr_hold_data", wr0, pat_a5);
        chk("dwr_hold_addr", addr0, 32'h0000_1FC0);
        chk("dwr_hold_op", op0, 1'b1);
        L2_ack = 1'b1; D_cache_req = 1'b0;
        #1 chk("dwr_ack", d_ack0, 1'b1);
        tick(); L2_ack = 1'b0;
        #1 chk("dwr_idle", own0, 2'b00);

        // Both requests from reset: u0 alternates D,I,D,I; u1 always D
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        I_cache_req = 1'b1; I_cache_req_addr = 32'h8000_007F;
        D_cache_req = 1'b1; D_cache_req_op = 1'b1; D_cache_req_addr = 32'h4000_0123;
        D_cache_wr_data = pat_wr;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("both_own0_%0d", k), own0, exp_own0[k]);
            chk($sformatf("both_addr0_%0d", k), addr0, exp_addr0[k]);
            chk($sformatf("both_op0_%0d", k), op0, exp_op0[k]);
            chk($sformatf("both_own1_%0d", k), own1, 2'b10);
            L2_ack = 1'b1;
            #1 chk($sformatf("both_acks0_%0d", k), {i_ack0, d_ack0},
                   (exp_own0[k] == 2'b01) ? 2'b10 : 2'b01);
            chk($sformatf("both_acks1_%0d", k), {i_ack1, d_ack1}, 2'b01);
            tick(); L2_ack = 1'b0;
            #1 chk($sformatf("both_bubble_%0d", k), {own0, own1}, 4'b0000);
        end
        chk("both_wr_latched", wr0, pat_wr);
        I_cache_req = 1'b0; D_cache_req = 1'b0;

        // Spurious L2_ack in IDLE
        L2_ack = 1'b1; L2_rd_data = pat_a5;
        #1 chk("spur_acks", {i_ack0, d_ack0, i_ack1, d_ack1}, 4'b0000);
        chk("spur_rd", i_rd0 | d_rd0, 512'd0);
        tick(); L2_ack = 1'b0;
        #1 chk("spur_owner", {own0, own1}, 4'b0000);

        // I drops its request mid-grant; grant and ack still complete
        I_cache_req = 1'b1; I_cache_req_addr = 32'h0000_00C5;
        tick();
        chk("idrop_owner", own0, 2'b01);
        chk("idrop_owner1", own1, 2'b01);
        chk("idrop_addr", addr0, 32'h0000_00C0);
        I_cache_req = 1'b0;
        tick();
        chk("idrop_req_held", {req0, own0}, 3'b101);
        L2_ack = 1'b1; L2_rd_data = pat_rd;
        #1 chk("idrop_ack", {i_ack0, i_ack1}, 2'b11);
        chk("idrop_rd", i_rd0, pat_rd);
        chk("idrop_d_ack", {d_ack0, d_ack1}, 2'b00);
        tick(); L2_ack = 1'b0;
        #1 chk("idrop_idle", own0, 2'b00);

        // Reset two cycles into GNT_I
        I_cache_req = 1'b1; I_cache_req_addr = 32'h0000_0400;
        tick();
        chk("rmid_gnt", own0, 2'b01);
        tick();
        rst_n = 1'b0; L2_ack = 1'b1;
        #1 chk("rmid_req", req0, 1'b0);
        chk("rmid_owner", own0, 2'b00);
        chk("rmid_ack", {i_ack0, d_ack0}, 2'b00);
        chk("rmid_addr", addr0, 32'd0);
        tick();
        rst_n = 1'b1; L2_ack = 1'b0; I_cache_req = 1'b0;
        D_cache_req = 1'b1; D_cache_req_op = 1'b0; D_cache_req_addr = 32'hFFFF_FFFF;
        tick();
        chk("post_rst_owner", own0, 2'b10);
        chk("post_rst_addr", addr0, 32'hFFFF_FFC0);
        L2_ack = 1'b1; D_cache_req = 1'b0;
        #1 chk("post_rst_ack", d_ack0, 1'b1);
        tick(); L2_ack = 1'b0;
        #1 chk("post_rst_idle", own0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
